// File: rtl/beq_branch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : beq_branch_unit_if
//  Description : Operand-load and compare bus for beq_branch_unit.
//                master drives write, i1, i2 and eorne, and receives the
//                register contents and the branch decision.
//                slave is the branch unit side.
//  Signals     : write        - shared write enable for both operand registers
//                i1, i2       - operand register data inputs
//                eorne        - 1 = branch-if-equal, 0 = branch-if-not-equal
//                oreg1, oreg2 - current operand register contents
//                branchdecide - 1 = take branch (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
interface beq_branch_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             write;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic             eorne;
    logic [WIDTH-1:0] oreg1;
    logic [WIDTH-1:0] oreg2;
    logic             branchdecide;

    modport master (
        output write,
        output i1,
        output i2,
        output eorne,
        input  oreg1,
        input  oreg2,
        input  branchdecide
    );

    modport slave (
        input  write,
        input  i1,
        input  i2,
        input  eorne,
        output oreg1,
        output oreg2,
        output branchdecide
    );
endinterface
`default_nettype wire

// File: rtl/beq_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : beq_branch_unit
//  Description : Two WIDTH-bit operand registers sharing one write enable,
//                followed by a purely combinational equality comparator that
//                produces a beq/bne branch decision.
//  Ports       : clk  - clock, all state updates on the rising edge
//                rst  - synchronous active-high reset, loads RESET_VALUE
//                bus  - beq_branch_unit_if.slave
//                       write/i1/i2 load the registers (one-edge latency)
//                       eorne selects beq (1) or bne (0)
//                       oreg1/oreg2 expose the registers
//                       branchdecide is the branch-taken decision
//  Revision    : 1.0 - initial release
// ============================================================================
module beq_branch_unit #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    beq_branch_unit_if.slave    bus
);

    // Operand registers: the only state in the block.
    logic [WIDTH-1:0] r_reg1;
    logic [WIDTH-1:0] r_reg2;

    // Comparator result and final decision.
    logic             w_equal;
    logic             w_decide;

    // Reset wins over write; with write low both registers hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg1 <= RESET_VALUE;
            r_reg2 <= RESET_VALUE;
        end else if (bus.write) begin
            r_reg1 <= bus.i1;
            r_reg2 <= bus.i2;
        end
    end

    // Pure bitwise equality; no signed or magnitude interpretation.
    // eorne is not registered so a mode change is visible within the cycle.
    always_comb begin
        w_equal  = (r_reg1 == r_reg2);
        w_decide = bus.eorne ? w_equal : ~w_equal;
    end

    assign bus.oreg1        = r_reg1;
    assign bus.oreg2        = r_reg2;
    assign bus.branchdecide = w_decide;

endmodule
`default_nettype wire

// File: tb/tb_beq_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beq_branch_unit
//  Description : Scoreboard bench for beq_branch_unit. The stimulus process
//                drives one vector per cycle at the falling edge and queues
//                the register/decision values expected just after the next
//                rising edge; a monitor pops and compares after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beq_branch_unit;

    localparam int unsigned C_WIDTH = 16;

    typedef struct packed {
        logic [C_WIDTH-1:0] o1;
        logic [C_WIDTH-1:0] o2;
        logic               bd;
    } exp_t;

    logic clk;
    logic rst;

    beq_branch_unit_if #(.WIDTH(C_WIDTH)) bus ();

    beq_branch_unit #(
        .WIDTH       (C_WIDTH),
        .RESET_VALUE (16'h0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t q_exp[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: drive at the falling edge, expect after the next rising edge.
    task automatic drive(input logic r, input logic w,
                         input logic [C_WIDTH-1:0] a, input logic [C_WIDTH-1:0] b,
                         input logic m,
                         input logic [C_WIDTH-1:0] e1, input logic [C_WIDTH-1:0] e2,
                         input logic ebd);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.write = w;
        bus.i1    = a;
        bus.i2    = b;
        bus.eorne = m;
        e.o1 = e1;
        e.o2 = e2;
        e.bd = ebd;
        q_exp.push_back(e);
    endtask

    // Monitor: compare one queued expectation after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_vec = n_vec + 1;
                if (bus.oreg1 !== e.o1 || bus.oreg2 !== e.o2 || bus.branchdecide !== e.bd) begin
                    n_fail = n_fail + 1;
                    $display("FAIL vec%0d: got oreg1=%h oreg2=%h bd=%b, need oreg1=%h oreg2=%h bd=%b",
                             n_vec, bus.oreg1, bus.oreg2, bus.branchdecide, e.o1, e.o2, e.bd);
                end
            end
        end
    end

    initial begin
        logic [C_WIDTH-1:0] v;
        int                 guard;
        rst       = 1'b1;
        bus.write = 1'b0;
        bus.i1    = '0;
        bus.i2    = '0;
        bus.eorne = 1'b1;

        // Reset state, both modes.
        drive(1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 1);
        drive(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);

        // beq sweep then bne sweep over 0..9 x 0..9.
        for (int a = 0; a < 10; a++)
            for (int b = 0; b < 10; b++)
                drive(0, 1, 16'(a), 16'(b), 1, 16'(a), 16'(b), (a == b));
        for (int a = 0; a < 10; a++)
            for (int b = 0; b < 10; b++)
                drive(0, 1, 16'(a), 16'(b), 0, 16'(a), 16'(b), (a != b));

        // Hold: load 0x1234 pair, then write low with other data for 3 edges.
        drive(0, 1, 16'h1234, 16'h1234, 1, 16'h1234, 16'h1234, 1);
        for (int k = 0; k < 3; k++)
            drive(0, 0, 16'h0001, 16'hFFFF, 1, 16'h1234, 16'h1234, 1);

        // Mid-operation reset discards contents.
        drive(1, 0, 16'h0001, 16'hFFFF, 1, 16'h0000, 16'h0000, 1);

        // Mode toggle with registers holding 0x00FF / 0x00FE.
        drive(0, 1, 16'h00FF, 16'h00FE, 1, 16'h00FF, 16'h00FE, 0);
        drive(0, 0, 16'h0000, 16'h0000, 0, 16'h00FF, 16'h00FE, 1);
        drive(0, 0, 16'h0000, 16'h0000, 1, 16'h00FF, 16'h00FE, 0);

        // Reset priority over write.
        drive(1, 1, 16'hAAAA, 16'h5555, 1, 16'h0000, 16'h0000, 1);
        drive(1, 1, 16'hAAAA, 16'h5555, 0, 16'h0000, 16'h0000, 0);

        // Boundaries.
        drive(0, 1, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 16'hFFFF, 1);
        drive(0, 1, 16'hFFFF, 16'h7FFF, 1, 16'hFFFF, 16'h7FFF, 0);
        drive(0, 0, 16'hFFFF, 16'h7FFF, 0, 16'hFFFF, 16'h7FFF, 1);
        drive(0, 1, 16'h8000, 16'h0000, 1, 16'h8000, 16'h0000, 0);
        drive(0, 1, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 1);

        // Single-bit difference in every position, both modes.
        for (int k = 0; k < C_WIDTH; k++) begin
            v = 16'h0001 << k;
            drive(0, 1, 16'h0000, v, 1, 16'h0000, v, 0);
            drive(0, 1, v, 16'h0000, 0, v, 16'h0000, 1);
        end

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (q_exp.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard = guard + 1;
        end
        #3;
        if (q_exp.size() > 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d pending, need 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/beq_branch_unit.md
BEQ_BRANCH_UNIT -- requirements
Module: beq_branch_unit

Interface
REQ-001 Parameter WIDTH, default 16: data width of both operand registers and the comparator.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into both operand registers on reset.
REQ-003 CLK  input  1: single clock; all state updates on the rising edge.
REQ-004 Reset  input  1: reset, synchronous, active-high.
REQ-005 Write  input  1: shared write enable for both operand registers.
REQ-006 I1  input  WIDTH: data input of operand register 1.
REQ-007 I2  input  WIDTH: data input of operand register 2.
REQ-008 EorNE  input  1: compare mode; 1 = branch-if-equal (beq), 0 = branch-if-not-equal (bne).
REQ-009 Oreg1  output  WIDTH: current contents of operand register 1.
REQ-010 Oreg2  output  WIDTH: current contents of operand register 2.
REQ-011 BranchDecide  output  1: branch-taken decision; 1 = take branch.

Function
REQ-012 The block SHALL contain two independent WIDTH-bit registers, reg1 driving Oreg1 and reg2 driving Oreg2, with no other state.
REQ-013 On a rising CLK edge with Reset=0 and Write=1, reg1 SHALL load I1 and reg2 SHALL load I2 in the same edge.
REQ-014 On a rising CLK edge with Reset=0 and Write=0, both registers SHALL hold their value.
REQ-015 Write latency SHALL be one edge: Oreg1/Oreg2 reflect I1/I2 sampled at the edge, valid immediately after that edge; changes of I1/I2 between edges SHALL NOT affect outputs.
REQ-016 BranchDecide SHALL be purely combinational from Oreg1, Oreg2 and EorNE, with no register stage.
REQ-017 With EorNE=1, BranchDecide SHALL be 1 iff Oreg1 == Oreg2 (all WIDTH bits), else 0.
REQ-018 With EorNE=0, BranchDecide SHALL be 1 iff Oreg1 != Oreg2 (any bit differs), else 0.
REQ-019 A change of EorNE SHALL change BranchDecide in the same cycle without a clock edge.
REQ-020 Comparison SHALL be bitwise equality only; no signed/unsigned ordering or magnitude interpretation.
REQ-021 Boundary values SHALL compare exactly: 0x0000 vs 0x0000 equal; 0xFFFF vs 0xFFFF equal; 0x8000 vs 0x0000 unequal; a single-bit difference in any position unequal.
REQ-022 Outputs SHALL never be X/Z after the first reset edge, for any known input.

Reset
REQ-023 On a rising CLK edge with Reset=1, reg1 and reg2 SHALL both load RESET_VALUE, regardless of Write, I1, I2.
REQ-024 Reset SHALL take priority over Write when both are 1 in the same edge.
REQ-025 After reset with RESET_VALUE=0, Oreg1=Oreg2=0x0000; BranchDecide SHALL be 1 for EorNE=1 and 0 for EorNE=0.
REQ-026 Reset asserted mid-operation SHALL discard prior register contents at that edge; no asynchronous effect between edges.
REQ-027 Before the first reset edge, register contents are unspecified; the bench SHALL apply reset first.

Verification
REQ-028 beq sweep: EorNE=1, Write=1, I1 and I2 each over 0..9 (all 100 pairs), one edge per pair -> BranchDecide=1 exactly when I1==I2, else 0.
REQ-029 bne sweep: EorNE=0, same 100 pairs -> BranchDecide=1 exactly when I1!=I2, else 0.
REQ-030 Hold: load I1=0x1234, I2=0x1234, then Write=0 with I1=0x0001, I2=0xFFFF for 3 edges -> Oreg1=Oreg2=0x1234, BranchDecide=1 (EorNE=1) throughout.
REQ-031 Mode toggle: Oreg1=0x00FF, Oreg2=0x00FE, toggle EorNE 1->0 with no edge -> BranchDecide goes 0->1 combinationally.
REQ-032 Reset priority: Reset=1, Write=1, I1=0xAAAA, I2=0x5555 at an edge -> Oreg1=Oreg2=0x0000, BranchDecide=1 with EorNE=1.
REQ-033 Boundary: load 0xFFFF/0xFFFF -> equal; then 0xFFFF/0x7FFF -> unequal (EorNE=1 gives 0, EorNE=0 gives 1).
